// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - RV32I 5-stage pipeline hazard sequencer
// Stall/flush/forward decode, memory-wait tracking with timeout, activity counters.
module hazard_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic [4:0]       rs1E,
  input  logic [4:0]       rs2E,
  input  logic [4:0]       rdE,
  input  logic [4:0]       rdM,
  input  logic [4:0]       rdW,
  input  logic             LoadE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             dmem_reqM,
  input  logic             dmem_readyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX   = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [0:0]        RUN      = 1'b0;
  localparam logic [0:0]        MEM_WAIT = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_err_q, mem_err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic mem_wait;
  logic lw_stall;

  assign mem_wait = dmem_reqM & ~dmem_readyM;
  assign lw_stall = LoadE & (rdE != 5'd0) & ((rdE == rs1D) | (rdE == rs2D));

  always_comb begin
    ForwardAE = 2'b00;
    if (RegWriteM && (rdM != 5'd0) && (rdM == rs1E))      ForwardAE = 2'b10;
    else if (RegWriteW && (rdW != 5'd0) && (rdW == rs1E)) ForwardAE = 2'b01;
  end

  always_comb begin
    ForwardBE = 2'b00;
    if (RegWriteM && (rdM != 5'd0) && (rdM == rs2E))      ForwardBE = 2'b10;
    else if (RegWriteW && (rdW != 5'd0) && (rdW == rs2E)) ForwardBE = 2'b01;
  end

  // FlushD drives an async clear: kept to a single AND of PCSrcE, memWait and reset.
  assign FlushD = rst & PCSrcE & ~mem_wait;
  assign FlushE = rst & ~mem_wait & (PCSrcE | lw_stall);
  assign StallF = rst & (mem_wait | (~PCSrcE & lw_stall));
  assign StallD = StallF;
  assign StallE = rst & mem_wait;
  assign StallM = rst & mem_wait;
  assign FlushW = rst & mem_wait;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    case (state_q)
      RUN:      if (mem_wait) state_d = MEM_WAIT;
      MEM_WAIT: if (dmem_readyM | ~dmem_reqM) state_d = RUN;
      default:  state_d = RUN;
    endcase
    if (mem_wait) begin
      if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      if (wait_cnt_q >= WAIT_LAST) mem_err_d = 1'b1;
    end else begin
      wait_cnt_d = '0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (StallF && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (FlushD && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
